// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage memory instruction into a single
// word-aligned request/grant/rvalid transaction, with lane steering and load extension.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FUNCTION3  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Load,
  input  logic                  Store,
  input  logic [FUNCTION3-1:0]  fun3,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_wmask_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            dbg_state_o
);

  // Memory handshake: mem_req_o is raised only in REQ and the latched request
  // is held unchanged until a cycle with mem_gnt_i=1 accepts it; for a load the
  // single mem_rvalid_i pulse seen in WAIT carries the read word.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [FUNCTION3-1:0] F_B  = FUNCTION3'(0);
  localparam logic [FUNCTION3-1:0] F_H  = FUNCTION3'(1);
  localparam logic [FUNCTION3-1:0] F_W  = FUNCTION3'(2);
  localparam logic [FUNCTION3-1:0] F_BU = FUNCTION3'(4);
  localparam logic [FUNCTION3-1:0] F_HU = FUNCTION3'(5);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [FUNCTION3-1:0]  fun3_q, fun3_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic is_b, is_h, is_w, is_bu, is_hu;
  logic fun_ok, misaligned, one_op, in_idle;
  logic req_ok, req_bad;

  // Request decode; unsigned sizes are load-only, so a store with BU/HU is illegal.
  always_comb begin
    is_b       = (fun3 == F_B);
    is_h       = (fun3 == F_H);
    is_w       = (fun3 == F_W);
    is_bu      = (fun3 == F_BU);
    is_hu      = (fun3 == F_HU);
    fun_ok     = is_b | is_h | is_w | (Load & (is_bu | is_hu));
    misaligned = ((is_h | is_hu) & addr_i[0]) | (is_w & (addr_i[1:0] != 2'b00));
    one_op     = Load ^ Store;
    in_idle    = (state_q == S_IDLE);
    req_ok     = in_idle & one_op & fun_ok & ~misaligned;
    req_bad    = in_idle & (Load | Store) & ~(one_op & fun_ok & ~misaligned);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_ok) state_d = S_REQ;
      S_REQ:  if (mem_gnt_i) state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT: if (mem_rvalid_i) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_fmt;

  // Lane extraction uses the latched low address bits and size of the load.
  always_comb begin
    byte_sel = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (fun3_q)
      F_B:     load_fmt = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F_BU:    load_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F_H:     load_fmt = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F_HU:    load_fmt = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_fmt = mem_rdata_i;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fun3_d  = fun3_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = req_bad;
    if (req_ok) begin
      addr_d  = addr_i;
      wdata_d = wdata_i;
      fun3_d  = fun3;
      we_d    = Store;
    end
    if ((state_q == S_WAIT) && mem_rvalid_i) rdata_d = load_fmt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      fun3_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fun3_q  <= fun3_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  logic [3:0]            store_mask;
  logic [DATA_WIDTH-1:0] store_data;

  // Store data is replicated so every lane the mask enables sees the right bytes.
  always_comb begin
    case (fun3_q)
      F_B: begin
        store_mask = 4'b0001 << addr_q[1:0];
        store_data = {(DATA_WIDTH/8){wdata_q[7:0]}};
      end
      F_H: begin
        store_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        store_data = {(DATA_WIDTH/16){wdata_q[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  assign mem_req_o   = rst_n & (state_q == S_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_wdata_o = store_data;
  assign mem_wmask_o = we_q ? store_mask : 4'b0000;
  assign rdata_o     = rdata_q;
  assign stall_o     = rst_n & (req_ok | (state_q == S_REQ) | (state_q == S_WAIT));
  assign done_o      = rst_n & (state_q == S_DONE);
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a
// lane-level reference model, with a queue-based scoreboard on the DUT outputs.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Load = 1'b0, Store = 1'b0;
  logic [2:0]  fun3 = 3'd0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] rdata_o;
  logic        stall_o, done_o, err_o;
  logic [1:0]  dbg_state_o;

  load_store_unit #(.DATA_WIDTH(32), .FUNCTION3(3)) dut (
    .clk(clk), .rst_n(rst_n), .Load(Load), .Store(Store), .fun3(fun3),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .done_o(done_o), .err_o(err_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [7:0]  len;
  } req_t;

  typedef struct packed {
    logic        is_err;
    logic        is_load;
    logic [7:0]  lat;
    logic [31:0] acc;
    logic [31:0] rdata;
  } cpl_t;

  logic [$bits(req_t)-1:0] exp_req_q[$];
  logic [$bits(cpl_t)-1:0] exp_cpl_q[$];

  // ---------------- reference model ----------------
  function automatic void ref_model(input bit ld, input bit st, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, output bit legal,
                                    output logic [31:0] wword, output logic [3:0] mask,
                                    output logic [31:0] lres);
    int     size;
    bit     sgn;
    int     off;
    longint v;
    size = 0;
    sgn  = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    off   = int'(addr[1:0]);
    legal = (ld != st) && (size != 0) && !(st && f3[2]);
    if (legal && ((off % size) != 0)) legal = 0;
    wword = '0;
    mask  = '0;
    lres  = '0;
    if (size != 0) begin
      for (int i = 0; i < 4; i++) begin
        wword[8*i +: 8] = wdata[8*(i % size) +: 8];
        if (i >= off && i < off + size) mask[i] = 1'b1;
      end
      v = longint'(rdata) >> (8 * off);
      v = v & ((64'd1 << (8 * size)) - 1);
      if (sgn && v[8*size-1]) v = v - (64'd1 << (8 * size));
      lres = v[31:0];
    end
  endfunction

  // ---------------- memory responder ----------------
  int          gnt_dly = 0, rv_dly = 0, gcnt = 0, rcnt = 0;
  bit          rv_pending = 0;
  logic [31:0] rdata_cur = '0;

  always @(negedge clk) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom();
    if (mem_req_o) begin
      if (gcnt >= gnt_dly) begin
        mem_gnt_i  = 1'b1;
        gcnt       = 0;
        rv_pending = !mem_we_o;
        rcnt       = 0;
      end else gcnt++;
    end else begin
      gcnt = 0;
      if (rv_pending) begin
        if (rcnt >= rv_dly) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rdata_cur;
          rv_pending   = 0;
        end else rcnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  req_t        cur_req;
  cpl_t        cur_cpl;
  int          req_len = 0;
  logic        rst_prev = 1'b0;
  logic [31:0] model_rdata = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_mem_req", mem_req_o, 0);
      chk("reset_stall", stall_o, 0);
      req_len = 0;
    end else begin
      if (!rst_prev) model_rdata = '0;
      if (mem_req_o) begin
        if (req_len == 0) begin
          chk("req_expected", exp_req_q.size() != 0, 1);
          if (exp_req_q.size() != 0) cur_req = exp_req_q.pop_front();
        end
        req_len++;
        chk("req_addr", mem_addr_o, cur_req.addr);
        chk("req_we", mem_we_o, cur_req.we);
        if (cur_req.we) begin
          chk("req_wdata", mem_wdata_o, cur_req.wdata);
          chk("req_wmask", mem_wmask_o, cur_req.mask);
        end
      end else if (req_len != 0) begin
        chk("req_hold_cycles", req_len, cur_req.len);
        req_len = 0;
      end
      if (done_o || err_o) begin
        chk("cpl_expected", exp_cpl_q.size() != 0, 1);
        chk("done_err_exclusive", done_o & err_o, 0);
        if (exp_cpl_q.size() != 0) begin
          cur_cpl = exp_cpl_q.pop_front();
          chk("cpl_kind_err", err_o, cur_cpl.is_err);
          chk("cpl_latency", cyc - int'(cur_cpl.acc), cur_cpl.lat);
          if (done_o && cur_cpl.is_load) model_rdata = cur_cpl.rdata;
        end
      end
      chk("rdata_o", rdata_o, model_rdata);
    end
    rst_prev = rst_n;
  end

  // ---------------- driver ----------------
  task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gd, input int rd);
    bit          legal;
    logic [31:0] ww, lr;
    logic [3:0]  mk;
    req_t        rq;
    cpl_t        cp;
    int          lat, stalls;
    ref_model(ld, st, f3, addr, wdata, rdata, legal, ww, mk, lr);
    lat = !legal ? 1 : (st ? 2 + gd : 3 + gd + rd);
    gnt_dly   = gd;
    rv_dly    = rd;
    rdata_cur = rdata;
    @(posedge clk); #1;
    Load = ld; Store = st; fun3 = f3; addr_i = addr; wdata_i = wdata;
    if (legal) begin
      rq.addr  = {addr[31:2], 2'b00};
      rq.we    = st;
      rq.wdata = ww;
      rq.mask  = mk;
      rq.len   = 8'(gd + 1);
      exp_req_q.push_back(rq);
    end
    cp.is_err  = !legal;
    cp.is_load = ld && legal;
    cp.lat     = 8'(lat);
    cp.acc     = cyc;
    cp.rdata   = lr;
    exp_cpl_q.push_back(cp);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      stalls++;
      if (i == 39) chk("stall_release", stall_o, 0);
    end
    chk("stall_cycles", stalls, legal ? lat : 0);
    @(posedge clk); #1;
    Load = 1'b0; Store = 1'b0;
    @(negedge clk);
    chk("idle_stall", stall_o, 0);
    chk("idle_mem_req", mem_req_o, 0);
  endtask

  task automatic reset_in_wait();
    req_t rq;
    gnt_dly   = 0;
    rv_dly    = 6;
    rdata_cur = 32'h1234_5678;
    rq.addr  = 32'h0000_0400;
    rq.we    = 1'b0;
    rq.wdata = '0;
    rq.mask  = '0;
    rq.len   = 8'd1;
    @(posedge clk); #1;
    Load = 1'b1; Store = 1'b0; fun3 = 3'd2; addr_i = 32'h0000_0400;
    exp_req_q.push_back(rq);
    @(posedge clk); #1;
    Load = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("abandon_state_idle", dbg_state_o, 0);
    chk("abandon_rdata_clear", rdata_o, 0);
    chk("abandon_no_done", done_o, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_state", dbg_state_o, 0);
    chk("post_reset_rdata", rdata_o, 0);
    chk("post_reset_done", done_o, 0);
    chk("post_reset_err", err_o, 0);
    chk("post_reset_req", mem_req_o, 0);

    access(0, 1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);  // SW
    access(0, 1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);  // SB
    access(1, 0, 3'd0, 32'h0000_0202, 32'h0, 32'h0080_FF00, 0, 0);  // LB
    access(1, 0, 3'd4, 32'h0000_0202, 32'h0, 32'h0080_FF00, 0, 0);  // LBU
    access(1, 0, 3'd1, 32'h0000_0301, 32'h0, 32'h0, 0, 0);          // LH misaligned
    access(0, 1, 3'd2, 32'h0000_0302, 32'h1111_2222, 32'h0, 0, 0);  // SW misaligned
    access(1, 1, 3'd2, 32'h0000_0300, 32'h0, 32'h0, 0, 0);          // both set
    access(0, 1, 3'd5, 32'h0000_0300, 32'h0, 32'h0, 0, 0);          // store HU
    access(1, 0, 3'd2, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 3, 2);  // LW slow
    reset_in_wait();

    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 15);
      ld = (r < 7) || (r == 15);
      st = (r >= 7);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
        else if (f3[1:0] == 2'd1) a[0] = 1'b0;
      end
      access(ld, st, f3, a, $urandom(), $urandom(),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("req_queue_drained", exp_req_q.size(), 0);
    chk("cpl_queue_drained", exp_cpl_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the data and address width.
REQ-002 Parameter FUNCTION3, default 3, is the funct3 field width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 Load  input  1  load instruction in the execute stage, from the decoder.
REQ-006 Store  input  1  store instruction in the execute stage, from the decoder.
REQ-007 fun3  input  FUNCTION3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr_i  input  DATA_WIDTH  effective byte address (ALU result).
REQ-009 wdata_i  input  DATA_WIDTH  store data (rs2).
REQ-010 mem_req_o  output  1  memory request valid.
REQ-011 mem_we_o  output  1  1 = write, 0 = read.
REQ-012 mem_addr_o  output  DATA_WIDTH  word-aligned address, addr_i with bits [1:0] cleared.
REQ-013 mem_wdata_o  output  DATA_WIDTH  store data replicated onto the target byte lanes.
REQ-014 mem_wmask_o  output  4  byte-lane write enables.
REQ-015 mem_gnt_i  input  1  memory accepts the request this cycle.
REQ-016 mem_rvalid_i  input  1  read data valid.
REQ-017 mem_rdata_i  input  DATA_WIDTH  read word.
REQ-018 rdata_o  output  DATA_WIDTH  load result after lane extraction and extension, written back through the write-back mux.
REQ-019 stall_o  output  1  hold the pipeline.
REQ-020 done_o  output  1  one-cycle pulse when an access completes.
REQ-021 err_o  output  1  one-cycle pulse for a misaligned or illegal access.

Function
REQ-022 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-023 IDLE, (Load ^ Store) with an aligned address: SHALL latch addr_i, wdata_i, fun3 and the direction, then go to REQ.
REQ-024 stall_o SHALL be combinationally 1 in IDLE while a new request is presented, and 1 in REQ and WAIT.
REQ-025 stall_o SHALL be 0 in DONE and in IDLE with no request.
REQ-026 REQ: mem_req_o SHALL be 1, and mem_addr_o, mem_we_o, mem_wdata_o and mem_wmask_o SHALL be driven from the latched values and held stable until mem_gnt_i.
REQ-027 REQ with mem_gnt_i=1 on a store: SHALL go to DONE; on a load: SHALL go to WAIT.
REQ-028 mem_req_o SHALL be 0 in every state other than REQ.
REQ-029 WAIT with mem_rvalid_i=1: SHALL register the formatted load data into rdata_o and go to DONE.
REQ-030 mem_rvalid_i arriving in any state other than WAIT SHALL be ignored.
REQ-031 DONE: done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-032 Minimum latency SHALL be: store 2 cycles from acceptance to done_o; load 3 cycles. Each extra gnt or rvalid wait cycle adds one cycle.
REQ-033 Write mask SHALL be: B = 0001 shifted left by addr[1:0]; H = 0011 shifted left by addr[1]*2; W = 1111.
REQ-034 Store data SHALL be: B = byte replicated 4 times; H = halfword replicated 2 times; W = unchanged.
REQ-035 Load format SHALL select the byte at addr[1:0] or the halfword at addr[1], then sign-extend for B/H and zero-extend for BU/HU. W SHALL pass through.
REQ-036 Misalignment SHALL be detected as: H/HU with addr[0]=1, or W with addr[1:0]!=00.
REQ-037 On misalignment, or on Load and Store both 1, or on a fun3 value not listed in REQ-007, the block SHALL pulse err_o for one cycle, issue no memory request and stay in IDLE.
REQ-038 A store with fun3 of 100 or 101 SHALL be treated as illegal under REQ-037.
REQ-039 rdata_o SHALL hold its value until the next completed load.
REQ-040 New Load/Store inputs arriving while not in IDLE SHALL be ignored; the pipeline holds them through stall_o.

Reset
REQ-041 rst_n=0 at a clock edge SHALL force IDLE and clear rdata_o, all latched registers, done_o and err_o.
REQ-042 With rst_n=0, mem_req_o and stall_o SHALL be 0.
REQ-043 Reset asserted in REQ or WAIT SHALL abandon the access with no done_o, and a late mem_rvalid_i after reset SHALL be ignored.

Verification
REQ-044 SW: addr=0x100, wdata=0xDEADBEEF, gnt in the same cycle -> mem_wmask=1111, mem_wdata=0xDEADBEEF, done_o 2 cycles after acceptance.
REQ-045 SB: addr=0x103, wdata=0x000000A5 -> mem_addr=0x100, mem_wmask=1000, mem_wdata=0xA5A5A5A5.
REQ-046 LB then LBU: addr=0x202, mem_rdata=0x0080FF00 -> rdata_o=0xFFFFFF80 for LB, 0x00000080 for LBU; done_o 3 cycles after acceptance.
REQ-047 LH: addr=0x301, and separately SW: addr=0x302 -> err_o pulse, mem_req_o stays 0, stall_o low the following cycle.
REQ-048 LW with gnt delayed 3 cycles and rvalid delayed 2 more -> mem_req_o held with stable address for 4 cycles, stall_o high throughout, single done_o, rdata_o equals mem_rdata_i.
REQ-049 rst_n low during WAIT, then rvalid pulsed -> FSM in IDLE, no done_o, rdata_o=0.
